// File: rtl/cpu_pkg.sv
// Shared CPU-side constants and the program-loader state encoding.
package cpu_pkg;

   localparam int         INS_ADDR_W  = 6;
   localparam int         INS_W       = 32;
   localparam logic [7:0] LOADER_SYNC = 8'hA5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DATA  = 2'd2,
      CHECK = 2'd3
   } ldr_state_t;

endpackage

// File: rtl/ins_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// master: the loader itself; slave: the UART/memory environment around it.
interface ins_loader_if
   import cpu_pkg::*;
#(
   parameter int ADDR_W = INS_ADDR_W,
   parameter int DATA_W = INS_W
);
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   modport master (
      input  in_data, in_valid,
      output in_ready, wr_en, wr_addr, wr_data
   );

   modport slave (
      output in_data, in_valid,
      input  in_ready, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/ins_word_pack.sv
// Little-endian byte-to-word packer with running modulo-256 byte sum.
// The 4th byte is not stored: the word is presented combinationally with it.
module ins_word_pack
   import cpu_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [7:0]       byte_in,
   output logic             word_valid,
   output logic [INS_W-1:0] word,
   output logic [7:0]       sum
);

   logic [1:0]  byte_idx_q;
   logic [23:0] sh_q;
   logic [7:0]  sum_q;

   // Byte lane capture, byte index and checksum accumulation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_idx_q <= 2'd0;
         sh_q       <= 24'd0;
         sum_q      <= 8'd0;
      end else if (clr) begin
         byte_idx_q <= 2'd0;
         sum_q      <= 8'd0;
      end else if (en) begin
         case (byte_idx_q)
            2'd0:    sh_q[7:0]   <= byte_in;
            2'd1:    sh_q[15:8]  <= byte_in;
            2'd2:    sh_q[23:16] <= byte_in;
            default: ;
         endcase
         byte_idx_q <= byte_idx_q + 2'd1;
         sum_q      <= sum_q + byte_in;
      end
   end

   assign word_valid = en & (byte_idx_q == 2'd3);
   assign word       = {byte_in, sh_q};
   assign sum        = sum_q;

endmodule

// File: rtl/ins_loader.sv
// Program loader: framed byte stream -> sequential instruction-memory writes.
// state | meaning
// IDLE  | drop bytes until the sync header
// COUNT | next byte is the word count N (0 = full depth)
// DATA  | packing 4*N data bytes, one write per completed word
// CHECK | next byte is the checksum; good -> release CPU, bad -> sticky err
module ins_loader
   import cpu_pkg::*;
#(
   parameter int         ADDR_W      = INS_ADDR_W,
   parameter int         DATA_W      = INS_W,
   parameter logic [7:0] SYNC_BYTE   = LOADER_SYNC,
   parameter int         TIMEOUT_CYC = 1000000
)(
   input  logic            clk,
   input  logic            rst_n,
   ins_loader_if.master    bus,
   output logic            cpu_hold,
   output logic            done,
   output logic            err
);

   localparam int                CNT_W    = ADDR_W + 1;
   localparam int                DEPTH    = 1 << ADDR_W;
   localparam int                TMR_W    = $clog2(TIMEOUT_CYC);
   localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

   ldr_state_t        state_q, state_d;
   logic              in_ready_q, acc;
   logic              pack_clr, pack_en, word_valid;
   logic [INS_W-1:0]  word;
   logic [7:0]        sum;
   logic [CNT_W-1:0]  n_q, n_in, word_cnt_q;
   logic [TMR_W-1:0]  timer_q;
   logic              last_word, timeout, sum_ok;
   logic              wr_en_d, done_d, err_d, hold_d;
   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [DATA_W-1:0] wr_data_q;

   assign acc       = bus.in_valid & in_ready_q;
   assign n_in      = (bus.in_data == 8'd0) ? CNT_W'(DEPTH) : CNT_W'(bus.in_data);
   assign last_word = (word_cnt_q == n_q - 1'b1);
   assign timeout   = (state_q != IDLE) && !acc && (timer_q == TMR_LAST);
   assign pack_clr  = (state_q == COUNT);
   assign pack_en   = (state_q == DATA) && acc;
   assign sum_ok    = (bus.in_data == sum);

   ins_word_pack u_pack (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (pack_clr),
      .en         (pack_en),
      .byte_in    (bus.in_data),
      .word_valid (word_valid),
      .word       (word),
      .sum        (sum)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state decode; a mid-frame stall longer than the timeout drops back to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (acc && bus.in_data == SYNC_BYTE) state_d = COUNT;
         COUNT: if (timeout) state_d = IDLE; else if (acc) state_d = DATA;
         DATA:  if (timeout) state_d = IDLE; else if (word_valid && last_word) state_d = CHECK;
         CHECK: if (timeout || acc) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode; values are registered below so every output is glitch-free.
   always_comb begin
      wr_en_d = word_valid;
      done_d  = 1'b0;
      err_d   = err;
      hold_d  = cpu_hold;
      case (state_q)
         IDLE:
            if (acc && bus.in_data == SYNC_BYTE) begin
               err_d  = 1'b0;
               hold_d = 1'b1;
            end
         CHECK:
            if (acc) begin
               if (sum_ok) begin
                  done_d = 1'b1;
                  hold_d = 1'b0;
               end else begin
                  err_d = 1'b1;
               end
            end
         default: ;
      endcase
      if (timeout) err_d = 1'b1;
   end

   // Output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready_q <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
         cpu_hold   <= 1'b0;
      end else begin
         in_ready_q <= 1'b1;
         wr_en_q    <= wr_en_d;
         done       <= done_d;
         err        <= err_d;
         cpu_hold   <= hold_d;
         if (wr_en_d) begin
            wr_addr_q <= word_cnt_q[ADDR_W-1:0];
            wr_data_q <= DATA_W'(word);
         end
      end
   end

   // Word count, frame length and idle-cycle timer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_q        <= '0;
         word_cnt_q <= '0;
         timer_q    <= '0;
      end else begin
         if (state_q == COUNT && acc) begin
            n_q        <= n_in;
            word_cnt_q <= '0;
         end else if (word_valid) begin
            word_cnt_q <= word_cnt_q + 1'b1;
         end
         if (state_q == IDLE || acc || timeout) timer_q <= '0;
         else                                   timer_q <= timer_q + 1'b1;
      end
   end

   assign bus.in_ready = in_ready_q;
   assign bus.wr_en    = wr_en_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_data  = wr_data_q;

endmodule

// File: tb/tb_ins_loader.sv
// Directed bench for the program loader with hand-computed frames.
module tb_ins_loader;
   import cpu_pkg::*;

   typedef logic [7:0] byte_q_t[$];

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic cpu_hold, done, err;

   ins_loader_if #(.ADDR_W(6), .DATA_W(32)) bus ();

   ins_loader #(
      .ADDR_W(6), .DATA_W(32), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(50)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .cpu_hold(cpu_hold), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_cyc = 0;
   logic [5:0]  wa_q[$];
   logic [31:0] wd_q[$];
   int          wc_q[$];
   int          done_cnt = 0;
   int          done_cyc = 0;
   int          both_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.wr_en) begin
            wa_q.push_back(bus.wr_addr);
            wd_q.push_back(bus.wr_data);
            wc_q.push_back(cyc);
         end
         if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
         end
         if (done && bus.wr_en) both_cnt = both_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit ok;
      ok = 1'b0;
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      for (int t = 0; t < 20 && !ok; t++) begin
         ok = bus.in_ready;
         @(posedge clk);
         #1;
      end
      acc_cyc = cyc;
      chk("in_ready", {31'd0, ok}, 32'd1);
   endtask

   task automatic send_q(input byte_q_t q);
      foreach (q[i]) send_byte(q[i]);
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clr_log;
      wa_q.delete();
      wd_q.delete();
      wc_q.delete();
      done_cnt = 0;
      done_cyc = 0;
   endtask

   task automatic chk_wr(input string tag, input int idx, input logic [5:0] a, input logic [31:0] d);
      if (idx < wa_q.size()) begin
         chk({tag, "_addr"}, {26'd0, wa_q[idx]}, {26'd0, a});
         chk({tag, "_data"}, wd_q[idx], d);
      end else begin
         chk({tag, "_present"}, wa_q.size(), idx + 1);
      end
   endtask

   initial begin
      int w4, c_chk, s;
      logic [7:0] b0, b1, b2, b3;

      bus.in_valid = 1'b0;
      bus.in_data  = 8'd0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("rst_wr_en",    {31'd0, bus.wr_en},    32'd0);
      chk("rst_wr_addr",  {26'd0, bus.wr_addr},  32'd0);
      chk("rst_wr_data",  bus.wr_data,           32'd0);
      chk("rst_hold",     {31'd0, cpu_hold},     32'd0);
      chk("rst_done",     {31'd0, done},         32'd0);
      chk("rst_err",      {31'd0, err},          32'd0);
      rst_n = 1'b1;
      idle(2);
      chk("ready_after_rst", {31'd0, bus.in_ready}, 32'd1);

      // single-word frame
      clr_log();
      send_byte(8'hA5);
      send_byte(8'h01);
      chk("t1_hold_busy", {31'd0, cpu_hold}, 32'd1);
      send_q('{8'h13, 8'h00, 8'h00, 8'h00});
      w4 = acc_cyc;
      send_byte(8'h13);
      c_chk = acc_cyc;
      idle(3);
      chk("t1_nwr", wa_q.size(), 1);
      chk_wr("t1_w0", 0, 6'd0, 32'h00000013);
      if (wc_q.size() > 0) chk("t1_wr_lat", wc_q[0], w4);
      chk("t1_done_cnt", done_cnt, 1);
      chk("t1_done_lat", done_cyc, c_chk);
      chk("t1_hold", {31'd0, cpu_hold}, 32'd0);
      chk("t1_err",  {31'd0, err},      32'd0);

      // full-depth frame, back-to-back bytes 0..255, sum = 0x80
      clr_log();
      send_byte(8'hA5);
      send_byte(8'h00);
      s = 0;
      for (int i = 0; i < 256; i++) begin
         send_byte(8'(i));
         s = s + i;
      end
      chk("t2_sum_model", s % 256, 32'h80);
      send_byte(8'h80);
      idle(3);
      chk("t2_nwr", wa_q.size(), 64);
      for (int i = 0; i < 64; i++) begin
         b0 = 8'(4 * i); b1 = 8'(4 * i + 1); b2 = 8'(4 * i + 2); b3 = 8'(4 * i + 3);
         chk_wr("t2_w", i, 6'(i), {b3, b2, b1, b0});
         if (i > 0 && i < wc_q.size()) chk("t2_spacing", wc_q[i] - wc_q[i-1], 4);
      end
      chk("t2_done_cnt", done_cnt, 1);
      chk("t2_hold", {31'd0, cpu_hold}, 32'd0);

      // bad checksum: 2 words stay written, err set, CPU stays held
      clr_log();
      send_q('{8'hA5, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h00});
      idle(3);
      chk("t3_nwr", wa_q.size(), 2);
      chk_wr("t3_w0", 0, 6'd0, 32'h04030201);
      chk_wr("t3_w1", 1, 6'd1, 32'h08070605);
      chk("t3_err",  {31'd0, err},      32'd1);
      chk("t3_hold", {31'd0, cpu_hold}, 32'd1);
      chk("t3_done", done_cnt, 0);

      // timeout after two data bytes; header clears the previous err
      clr_log();
      send_byte(8'hA5);
      chk("t4_err_clr", {31'd0, err}, 32'd0);
      send_q('{8'h01, 8'h11, 8'h22});
      idle(49);
      chk("t4_err_early", {31'd0, err}, 32'd0);
      idle(1);
      chk("t4_err_to",  {31'd0, err},      32'd1);
      chk("t4_hold_to", {31'd0, cpu_hold}, 32'd1);
      chk("t4_nwr_to",  wa_q.size(), 0);
      clr_log();
      send_q('{8'hA5, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h14});
      idle(3);
      chk_wr("t4_w0", 0, 6'd0, 32'h12345678);
      chk("t4_done", done_cnt, 1);
      chk("t4_err",  {31'd0, err},      32'd0);
      chk("t4_hold", {31'd0, cpu_hold}, 32'd0);

      // junk in IDLE ignored; sync byte inside data is data
      clr_log();
      send_q('{8'h00, 8'hFF, 8'h13});
      idle(3);
      chk("t5_idle_nwr",  wa_q.size(), 0);
      chk("t5_idle_done", done_cnt, 0);
      chk("t5_idle_hold", {31'd0, cpu_hold}, 32'd0);
      send_q('{8'hA5, 8'h01, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h4A});
      idle(3);
      chk("t5_nwr", wa_q.size(), 1);
      chk_wr("t5_w0", 0, 6'd0, 32'h0000A5A5);
      chk("t5_done", done_cnt, 1);
      chk("t5_err", {31'd0, err}, 32'd0);

      // reset mid-frame after 6 data bytes
      clr_log();
      send_q('{8'hA5, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06});
      chk("t6_hold_busy", {31'd0, cpu_hold}, 32'd1);
      chk("t6_pre_nwr", wa_q.size(), 1);
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("t6_hold_rst", {31'd0, cpu_hold},   32'd0);
      chk("t6_wr_en_rst", {31'd0, bus.wr_en}, 32'd0);
      clr_log();
      idle(2);
      rst_n = 1'b1;
      idle(5);
      chk("t6_no_wr", wa_q.size(), 0);
      send_q('{8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h38});
      idle(3);
      chk("t6_nwr", wa_q.size(), 1);
      chk_wr("t6_w0", 0, 6'd0, 32'hEFBEADDE);
      chk("t6_done", done_cnt, 1);
      chk("t6_hold", {31'd0, cpu_hold}, 32'd0);
      chk("t6_err",  {31'd0, err},      32'd0);

      chk("no_done_wr_overlap", both_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
